// File: rtl/ps2_rx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_rx_pkg
// Shared types and constants for the PS/2 frame receiver:
//   ps2_state_e  - receiver FSM states
//   PAR_*        - parity mode selectors for the PARITY_MODE parameter
//   parity_ok()  - parity verdict from the XOR of data and parity bits
// ----------------------------------------------------------------------------
package ps2_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    CHECK  = 3'd4
  } ps2_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // ones_odd is 1 when data plus parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic ones_odd, input int mode);
    if (mode == PAR_ODD)
      return ones_odd;
    else if (mode == PAR_EVEN)
      return !ones_odd;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_in_filter.sv
// ----------------------------------------------------------------------------
// ps2_in_filter
// Input conditioning for the raw PS/2 lines: 2-FF synchronisers on both
// lines, a deglitcher on the clock line and a falling-edge pulse.
// Ports:
//   clk, resetN  - system clock, asynchronous active-low reset
//   kbd_clk      - raw PS/2 clock line (asynchronous)
//   kbd_dat      - raw PS/2 data line (asynchronous)
//   dat_sync     - synchronised data line, sample it when fall_pulse is high
//   fall_pulse   - one-cycle pulse on a 1->0 transition of the filtered clock
// Parameter:
//   FILTER_LEN   - consecutive differing samples needed to flip the filtered
//                  clock (>= 2)
// ----------------------------------------------------------------------------
module ps2_in_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic kbd_clk,
  input  logic kbd_dat,
  output logic dat_sync,
  output logic fall_pulse
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          clk_meta;
  logic          clk_sync;
  logic          dat_meta;
  logic          clk_filt;
  logic [CW-1:0] run_cnt;

  // Everything resets to 1 so an idle bus does not look like an edge
  // right after reset is released.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= kbd_clk;
      clk_sync <= clk_meta;
      dat_meta <= kbd_dat;
      dat_sync <= dat_meta;
    end
  end

  // run_cnt counts how long the synchronised clock has disagreed with the
  // filtered one; any agreeing sample restarts the count, so short glitches
  // never reach FILTER_LEN. fall_pulse takes the old filtered value, which
  // is 1 exactly when the flip is a falling edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_filt   <= 1'b1;
      run_cnt    <= '0;
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= 1'b0;
      if (clk_sync != clk_filt) begin
        if (run_cnt == CW'(FILTER_LEN - 1)) begin
          clk_filt   <= clk_sync;
          run_cnt    <= '0;
          fall_pulse <= clk_filt;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
// PS/2 device-to-host frame receiver with a first-word-fall-through FIFO.
// Frames: start(0), DATA_BITS data bits LSB first, optional parity, stop(1).
// Ports:
//   clk, resetN      - system clock, asynchronous active-low reset
//   kbd_clk, kbd_dat - raw PS/2 lines
//   dout             - FIFO head (0 when empty)
//   dout_valid       - FIFO non-empty
//   dout_ready       - consumer pops the head when dout_valid is high
//   fifo_count       - FIFO occupancy
//   parity_err       - pulse: parity mismatch
//   frame_err        - pulse: stop bit was 0
//   timeout_err      - pulse: frame abandoned after TIMEOUT_CYC idle cycles
//   overflow         - pulse: good frame dropped, FIFO full
//   err_count        - saturating count of cycles with any error pulse
//                      (only when PS2_FRAME_RX_ERR_CNT_EN is defined)
// Build option:
//   PS2_FRAME_RX_ERR_CNT_EN - adds the err_count output and its counter
// ----------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          kbd_clk,
  input  logic                          kbd_dat,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
`ifdef PS2_FRAME_RX_ERR_CNT_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic                 dat_sync;
  logic                 fall_pulse;

  ps2_state_e           state;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 stop_bit;
  logic [TW-1:0]        tcnt;

  logic                 busy;
  logic                 timed_out;
  logic                 in_check;
  logic                 par_pass;
  logic                 good;
  logic                 full;
  logic                 pop;
  logic                 push;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  ps2_in_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .resetN     (resetN),
    .kbd_clk    (kbd_clk),
    .kbd_dat    (kbd_dat),
    .dat_sync   (dat_sync),
    .fall_pulse (fall_pulse)
  );

  assign busy      = (state == DATA) || (state == PARITY) || (state == STOP);
  assign timed_out = busy && (tcnt == TW'(TIMEOUT_CYC));

  // Frame FSM and inactivity counter. The timeout wins over a coincident
  // fall_pulse so an abandoned frame never half-advances.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      stop_bit  <= 1'b0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall_pulse && !dat_sync) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (timed_out) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (fall_pulse) begin
            tcnt      <= '0;
            shift_reg <= {dat_sync, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BCW'(DATA_BITS - 1))
              state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            else
              bit_cnt <= bit_cnt + BCW'(1);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        PARITY: begin
          if (timed_out) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (fall_pulse) begin
            tcnt    <= '0;
            par_bit <= dat_sync;
            state   <= STOP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STOP: begin
          if (timed_out) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (fall_pulse) begin
            tcnt     <= '0;
            stop_bit <= dat_sync;
            state    <= CHECK;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          tcnt  <= '0;
          state <= IDLE;
        end
        default: begin
          tcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outcome of the CHECK cycle in priority order: framing, parity, overflow.
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign in_check    = (state == CHECK);
  assign par_pass    = parity_ok(^{shift_reg, par_bit}, PARITY_MODE);
  assign full        = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop         = dout_valid && dout_ready;
  assign good        = in_check && stop_bit && par_pass;
  assign frame_err   = in_check && !stop_bit;
  assign parity_err  = in_check && stop_bit && !par_pass;
  assign overflow    = good && full && !pop;
  assign push        = good && (!full || pop);
  assign timeout_err = timed_out;

  // FIFO bookkeeping; pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW + 1)'(1);
      else if (pop && !push)
        count <= count - (AW + 1)'(1);
    end
  end

  // Storage needs no reset: dout is gated by dout_valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= shift_reg;
  end

  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

`ifdef PS2_FRAME_RX_ERR_CNT_EN
  // Counts cycles, not individual pulses, and sticks at all-ones.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_count <= '0;
    end else if ((parity_err || frame_err || timeout_err || overflow)
                 && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_frame_rx
// Self-checking bench for ps2_frame_rx. Two instances: dut_a (odd parity,
// TIMEOUT_CYC = 200) and dut_b (no parity). A shared line driver is routed
// to one instance at a time by sel. Expected bytes go into per-instance
// queues; monitors pop and compare on every dout_valid && dout_ready.
// ----------------------------------------------------------------------------
module tb_ps2_frame_rx;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic line_clk = 1'b1;
  logic line_dat = 1'b1;
  logic sel = 1'b0;

  logic       kbd_clk_a, kbd_dat_a, kbd_clk_b, kbd_dat_b;
  logic [7:0] dout_a, dout_b;
  logic       dout_valid_a, dout_valid_b;
  logic       dout_ready_a = 1'b1;
  logic       dout_ready_b = 1'b1;
  logic [2:0] fifo_count_a, fifo_count_b;
  logic       perr_a, ferr_a, terr_a, ovf_a;
  logic       perr_b, ferr_b, terr_b, ovf_b;
`ifdef PS2_FRAME_RX_ERR_CNT_EN
  logic [15:0] err_count_a, err_count_b;
`endif

  logic       cur_valid;
  logic [7:0] cur_dout;
  logic [2:0] cur_count;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_par_a = 0, cnt_frm_a = 0, cnt_to_a = 0, cnt_ovf_a = 0;
  int cnt_err_b = 0;
  int exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovf = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] exp_a, exp_b;

  always #5 clk = ~clk;

  assign kbd_clk_a = sel ? 1'b1 : line_clk;
  assign kbd_dat_a = sel ? 1'b1 : line_dat;
  assign kbd_clk_b = sel ? line_clk : 1'b1;
  assign kbd_dat_b = sel ? line_dat : 1'b1;

  assign cur_valid = sel ? dout_valid_b : dout_valid_a;
  assign cur_dout  = sel ? dout_b : dout_a;
  assign cur_count = sel ? fifo_count_b : fifo_count_a;

  ps2_frame_rx #(
    .DATA_BITS(8), .PARITY_MODE(1), .FILTER_LEN(4),
    .TIMEOUT_CYC(200), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .resetN(resetN), .kbd_clk(kbd_clk_a), .kbd_dat(kbd_dat_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .fifo_count(fifo_count_a), .parity_err(perr_a), .frame_err(ferr_a),
    .timeout_err(terr_a), .overflow(ovf_a)
`ifdef PS2_FRAME_RX_ERR_CNT_EN
    , .err_count(err_count_a)
`endif
  );

  ps2_frame_rx #(
    .DATA_BITS(8), .PARITY_MODE(0), .FILTER_LEN(4),
    .TIMEOUT_CYC(200), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .resetN(resetN), .kbd_clk(kbd_clk_b), .kbd_dat(kbd_dat_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .fifo_count(fifo_count_b), .parity_err(perr_b), .frame_err(ferr_b),
    .timeout_err(terr_b), .overflow(ovf_b)
`ifdef PS2_FRAME_RX_ERR_CNT_EN
    , .err_count(err_count_b)
`endif
  );

  // Scoreboard monitors: compare every accepted head entry.
  always @(negedge clk) begin
    if (resetN && dout_valid_a && dout_ready_a) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL pop_a: got %0h expected nothing", dout_a);
      end else begin
        exp_a = q_a.pop_front();
        if (dout_a !== exp_a) begin
          n_errors++;
          $display("[TB] FAIL pop_a: got %0h expected %0h", dout_a, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetN && dout_valid_b && dout_ready_b) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL pop_b: got %0h expected nothing", dout_b);
      end else begin
        exp_b = q_b.pop_front();
        if (dout_b !== exp_b) begin
          n_errors++;
          $display("[TB] FAIL pop_b: got %0h expected %0h", dout_b, exp_b);
        end
      end
    end
  end

  // Pulse counters: a pulse longer than one cycle counts more than once.
  always @(negedge clk) begin
    if (perr_a) cnt_par_a++;
    if (ferr_a) cnt_frm_a++;
    if (terr_a) cnt_to_a++;
    if (ovf_a)  cnt_ovf_a++;
    if (perr_b || ferr_b || terr_b || ovf_b) cnt_err_b++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_errors(input string name);
    check_output({name, "_parity_pulses"},  cnt_par_a, exp_par);
    check_output({name, "_frame_pulses"},   cnt_frm_a, exp_frm);
    check_output({name, "_timeout_pulses"}, cnt_to_a,  exp_to);
    check_output({name, "_overflow_pulses"}, cnt_ovf_a, exp_ovf);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) line_dat = b;
    wait_cycles(10);
    line_clk = 1'b0;
    wait_cycles(20);
    line_clk = 1'b1;
    wait_cycles(9);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d,
                                             input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Sends len bits of fr LSB first. With probe set, the last falling edge
  // is the timing reference: CHECK is seen 7 negedges later and the FIFO
  // entry (if any) 8 negedges later.
  task automatic apply_stimulus(input string name, input logic [10:0] fr,
                                input int len, input bit probe,
                                input bit exp_push, input logic [7:0] exp_d);
    logic       v7, v8;
    logic [7:0] d8;
    logic [2:0] c8;
    if (exp_push) begin
      if (sel) q_b.push_back(exp_d);
      else     q_a.push_back(exp_d);
    end
    for (int i = 0; i < len; i++) begin
      if (probe && i == len - 1) begin
        @(negedge clk) line_dat = fr[i];
        wait_cycles(10);
        line_clk = 1'b0;
        wait_cycles(7);
        v7 = cur_valid;
        wait_cycles(1);
        v8 = cur_valid;
        d8 = cur_dout;
        c8 = cur_count;
        wait_cycles(12);
        line_clk = 1'b1;
        wait_cycles(9);
        check_output({name, "_valid_E+1"}, v7, 1'b0);
        check_output({name, "_valid_E+2"}, v8, exp_push);
        check_output({name, "_count_E+2"}, c8, exp_push ? 3'd1 : 3'd0);
        if (exp_push)
          check_output({name, "_dout_E+2"}, d8, exp_d);
      end else begin
        send_bit(fr[i]);
      end
    end
    line_dat = 1'b1;
    wait_cycles(20);
  endtask

  initial begin
    logic [7:0] tbl_d [5];
    logic       tbl_p [5];
    logic [10:0] fr;
    tbl_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    tbl_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    wait_cycles(3);
    check_output("rst_valid", dout_valid_a, 1'b0);
    check_output("rst_dout", dout_a, 8'h00);
    check_output("rst_count", fifo_count_a, 3'd0);
    check_output("rst_pulses", {perr_a, ferr_a, terr_a, ovf_a}, 4'b0000);
    @(negedge clk) resetN = 1'b1;
    wait_cycles(10);

    // 0x1C, three ones, odd parity bit 0
    $display("[TB] test 1: good frame 0x1C");
    apply_stimulus("t1", make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b1, 1'b1, 8'h1C);
    check_errors("t1");

    $display("[TB] test 2: parity error, then no-parity instance");
    apply_stimulus("t2", make_frame(8'h1C, 1'b1, 1'b1), 11, 1'b1, 1'b0, 8'h00);
    exp_par++;
    check_errors("t2");
    sel = 1'b1;
    wait_cycles(10);
    fr = {2'b11, 8'h1C, 1'b0};
    apply_stimulus("t2b", fr, 10, 1'b1, 1'b1, 8'h1C);
    sel = 1'b0;
    wait_cycles(10);
    check_output("t2b_no_err", cnt_err_b, 0);

    $display("[TB] test 3: bad stop bit with good parity");
    apply_stimulus("t3", make_frame(8'hAA, 1'b1, 1'b0), 11, 1'b1, 1'b0, 8'h00);
    exp_frm++;
    check_errors("t3");

    $display("[TB] test 4: timeout then 0xF0");
    fr = make_frame(8'hF0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      send_bit(fr[i]);
    line_dat = 1'b1;
    wait_cycles(300);
    exp_to++;
    check_errors("t4");
    apply_stimulus("t4", fr, 11, 1'b1, 1'b1, 8'hF0);

    $display("[TB] test 5: fill FIFO and overflow");
    @(posedge clk);
    #1 dout_ready_a = 1'b0;
    for (int i = 0; i < 5; i++)
      apply_stimulus("t5", make_frame(tbl_d[i], tbl_p[i], 1'b1), 11, 1'b0,
                     i < 4, tbl_d[i]);
    exp_ovf++;
    check_output("t5_count_full", fifo_count_a, 3'd4);
    check_output("t5_head", dout_a, 8'h01);
    check_errors("t5");
`ifdef PS2_FRAME_RX_ERR_CNT_EN
    check_output("t5_err_count", err_count_a, 16'd4);
`endif
    @(posedge clk);
    #1 dout_ready_a = 1'b1;
    for (int i = 0; i < 20 && q_a.size() != 0; i++)
      @(negedge clk);
    wait_cycles(1);
    check_output("t5_drained", q_a.size(), 0);
    check_output("t5_count_empty", fifo_count_a, 3'd0);

    $display("[TB] test 6: glitch, then reset mid-frame");
    @(negedge clk) line_dat = 1'b0;
    wait_cycles(5);
    line_clk = 1'b0;
    wait_cycles(2);
    line_clk = 1'b1;
    wait_cycles(5);
    line_dat = 1'b1;
    wait_cycles(30);
    check_output("t6_glitch_count", fifo_count_a, 3'd0);
    check_errors("t6_glitch");
    apply_stimulus("t6a", make_frame(8'h5A, 1'b1, 1'b1), 11, 1'b1, 1'b1, 8'h5A);
    check_errors("t6_after_glitch");

    @(posedge clk);
    #1 dout_ready_a = 1'b0;
    apply_stimulus("t6f", make_frame(8'h11, 1'b1, 1'b1), 11, 1'b0, 1'b0, 8'h00);
    apply_stimulus("t6f", make_frame(8'h22, 1'b1, 1'b1), 11, 1'b0, 1'b0, 8'h00);
    check_output("t6_count_two", fifo_count_a, 3'd2);
    fr = make_frame(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      send_bit(fr[i]);
    @(negedge clk) resetN = 1'b0;
    wait_cycles(2);
    check_output("t6_rst_valid", dout_valid_a, 1'b0);
    check_output("t6_rst_dout", dout_a, 8'h00);
    check_output("t6_rst_count", fifo_count_a, 3'd0);
    check_output("t6_rst_pulses", {perr_a, ferr_a, terr_a, ovf_a}, 4'b0000);
`ifdef PS2_FRAME_RX_ERR_CNT_EN
    check_output("t6_rst_err_count", err_count_a, 16'd0);
`endif
    @(negedge clk) resetN = 1'b1;
    @(posedge clk);
    #1 dout_ready_a = 1'b1;
    wait_cycles(10);
    apply_stimulus("t6b", fr, 11, 1'b1, 1'b1, 8'h3C);
    check_errors("t6_end");

    wait_cycles(20);
    check_output("end_queue_a", q_a.size(), 0);
    check_output("end_queue_b", q_b.size(), 0);
    check_output("end_no_err_b", cnt_err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
